// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: centres on the start bit, steps the core once per bit, checks the stop bit.
// Received bytes land in a show-ahead FIFO: data is visible the cycle after a push, and a push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_ctrl #(
  parameter int DataWidth = 8,
  parameter int Depth     = 8,
  parameter int DivWidth  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [DivWidth-1:0]      divisor_i,
  input  logic                     rxd_i,
  output logic                     baud_tick_o,
  input  logic                     rx_dv_i,
  input  logic [DataWidth-1:0]     rx_data_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [DataWidth-1:0]     rd_data_o,
  output logic [$clog2(Depth):0]   level_o,
  input  logic                     flush_i,
  input  logic                     clr_err_i,
  output logic                     overrun_o,
  output logic                     framing_err_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;
  localparam int IdxW = $clog2(DataWidth + 1);
  localparam logic [DivWidth-1:0] MinDiv = DivWidth'(4);
  localparam logic [DivWidth-1:0] DivOne = DivWidth'(1);
  localparam logic [IdxW-1:0]     StopIdx = IdxW'(DataWidth);
  localparam logic [IdxW-1:0]     IdxOne = IdxW'(1);
  localparam logic [LvlW-1:0]     LvlFull = LvlW'(Depth);
  localparam logic [LvlW-1:0]     LvlOne = LvlW'(1);
  localparam logic [PtrW-1:0]     PtrOne = PtrW'(1);

  typedef enum logic [1:0] {Idle, StartWait, Bits} state_e;

  state_e              state_q, state_d;
  logic [DivWidth-1:0] cnt_q, cnt_d, div_q, div_d, div_sel;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                rxd_meta, rxd_s, rxd_d;
  logic                tick, stop_err;

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]      level_q;
  logic                 overrun_q, framing_q;
  logic                 full, pop, push, ovr_set;

  // Two-flop sync plus one delay stage; mirrors the core so both see the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
    end else begin
      rxd_meta <= rxd_i;
      rxd_s    <= rxd_meta;
      rxd_d    <= rxd_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    idx_d    = idx_q;
    tick     = 1'b0;
    stop_err = 1'b0;
    div_sel  = (divisor_i < MinDiv) ? MinDiv : divisor_i;
    case (state_q)
      Idle: begin
        if (en_i && rxd_d && !rxd_s) begin
          div_d   = div_sel;
          cnt_d   = (div_sel >> 1) - DivOne;
          state_d = StartWait;
        end
      end
      StartWait: begin
        if (cnt_q == '0) begin
          // Tick fires even on a glitch so the core samples the high line and stays idle.
          tick = 1'b1;
          if (!rxd_s) begin
            cnt_d   = div_q - DivOne;
            idx_d   = '0;
            state_d = Bits;
          end else begin
            state_d = Idle;
          end
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end
      Bits: begin
        if (cnt_q == '0) begin
          tick = 1'b1;
          if (idx_q == StopIdx) begin
            stop_err = !rxd_s;
            state_d  = Idle;
          end else begin
            cnt_d = div_q - DivOne;
            idx_d = idx_q + IdxOne;
          end
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end
      default: state_d = Idle;
    endcase
  end

  assign baud_tick_o = tick;

  assign full    = (level_q == LvlFull);
  assign pop     = rd_valid_o && rd_ready_i;
  assign push    = rx_dv_i && (!full || pop);
  assign ovr_set = rx_dv_i && full && !pop && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      level_q <= level_q + LvlOne;
      else if (pop && !push) level_q <= level_q - LvlOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr_q] <= rx_data_i;
  end

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      if (ovr_set)        overrun_q <= 1'b1;
      else if (clr_err_i) overrun_q <= 1'b0;
      if (stop_err)       framing_q <= 1'b1;
      else if (clr_err_i) framing_q <= 1'b0;
    end
  end

  assign rd_valid_o    = (level_q != '0);
  assign rd_data_o     = rd_valid_o ? mem[rd_ptr_q] : '0;
  assign level_o       = level_q;
  assign overrun_o     = overrun_q;
  assign framing_err_o = framing_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames and FIFO traffic, compares against a queue-based model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] divisor = 16'd16;
  logic        rxd = 1'b1;
  logic        tick;
  logic        dv = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  rdata;
  logic [3:0]  level;
  logic        flush = 1'b0;
  logic        clr = 1'b0;
  logic        ovr, ferr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tq[$];
  logic [7:0] mq[$];
  logic m_ovr = 1'b0;
  logic m_ferr = 1'b0;

  uart_rx_ctrl #(.DataWidth(8), .Depth(DEPTH), .DivWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .divisor_i(divisor), .rxd_i(rxd),
    .baud_tick_o(tick), .rx_dv_i(dv), .rx_data_i(data),
    .rd_valid_o(rvalid), .rd_ready_i(rready), .rd_data_o(rdata), .level_o(level),
    .flush_i(flush), .clr_err_i(clr), .overrun_o(ovr), .framing_err_o(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && tick) tq.push_back(cyc);

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "/level"}, 32'(level), 32'(mq.size()));
    check({tag, "/valid"}, 32'(rvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) check({tag, "/data"}, 32'(rdata), 32'(mq[0]));
    check({tag, "/overrun"}, 32'(ovr), 32'(m_ovr));
    check({tag, "/framing"}, 32'(ferr), 32'(m_ferr));
  endtask

  // One bus cycle on the FIFO side; the model applies the same cycle to the queue.
  task automatic fifo_cyc(input logic d_v, input logic [7:0] d, input logic rdy,
                          input logic fl, input logic cl, input string tag);
    logic pop, full, ovs;
    dv = d_v; data = d; rready = rdy; flush = fl; clr = cl;
    pop  = rdy && (mq.size() != 0);
    full = (mq.size() == DEPTH);
    ovs  = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (d_v && full && !pop) ovs = 1'b1;
      if (pop) void'(mq.pop_front());
      if (d_v && (!full || pop)) mq.push_back(d);
    end
    m_ovr = ovs ? 1'b1 : (cl ? 1'b0 : m_ovr);
    if (cl) m_ferr = 1'b0;
    @(negedge clk);
    dv = 1'b0; rready = 1'b0; flush = 1'b0; clr = 1'b0;
    check_state(tag);
  endtask

  // Serial frame; ticks expected at edge-detect (drive cycle + 2) + eff/2, then every eff cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [15:0] dvsr,
                            input logic drop_en, input logic rdy, input string tag);
    int eff, c0;
    logic [9:0] bits;
    eff  = (dvsr < 16'd4) ? 4 : int'(dvsr);
    bits = {stop, b, 1'b0};
    tq.delete();
    divisor = dvsr;
    c0 = cyc;
    for (int j = 0; j < 10; j++) begin
      rxd = bits[j];
      if (j == 1) divisor = 16'($urandom_range(0, 40));
      if (drop_en && j == 2) en = 1'b0;
      repeat (eff) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b1;
    if (!stop) m_ferr = 1'b1;
    check({tag, "/tick_count"}, 32'(tq.size()), 32'd10);
    for (int j = 0; j < 10; j++)
      if (j < tq.size()) check({tag, "/tick_time"}, 32'(tq[j]), 32'(c0 + 2 + eff / 2 + j * eff));
    fifo_cyc(1'b1, b, rdy, 1'b0, 1'b0, tag);
  endtask

  task automatic glitch(input logic [15:0] dvsr);
    int eff, c0;
    eff = (dvsr < 16'd4) ? 4 : int'(dvsr);
    tq.delete();
    divisor = dvsr;
    c0 = cyc;
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (2 * eff) @(negedge clk);
    check("glitch/tick_count", 32'(tq.size()), 32'd1);
    if (tq.size() > 0) check("glitch/tick_time", 32'(tq[0]), 32'(c0 + 2 + eff / 2));
  endtask

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("reset/tick", 32'(tick), 32'd0);
    check("reset/rdata", 32'(rdata), 32'd0);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'hA5, 1'b1, 16'd16, 1'b0, 1'b0, "a5");
    glitch(16'd16);
    check_state("glitch");
    send_frame(8'h3C, 1'b0, 16'd16, 1'b0, 1'b0, "3c_stop0");
    fifo_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_ferr");
    fifo_cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush");

    for (int i = 0; i < 9; i++) fifo_cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
    fifo_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_ovr");
    fifo_cyc(1'b1, 8'h09, 1'b1, 1'b0, 1'b0, "full_push_pop");
    for (int i = 0; i < 8; i++) fifo_cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
    fifo_cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "empty_pop");

    send_frame(8'h5A, 1'b1, 16'd2, 1'b1, 1'b0, "div2_en_drop");

    // Disabled receiver ignores a start bit entirely.
    en = 1'b0;
    tq.delete();
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    check("disabled/tick_count", 32'(tq.size()), 32'd0);
    en = 1'b1;
    repeat (4) @(negedge clk);

    // Flush in the same cycle as a push and a pop.
    fifo_cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "pre_flush");
    fifo_cyc(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, "flush_push_pop");

    for (int it = 0; it < 12; it++) begin
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 20)),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, "rnd_frame");
      for (int k = 0; k < int'($urandom_range(3, 12)); k++)
        fifo_cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, "rnd_fifo");
    end

    // Reset mid-frame: ticks stop and the FIFO/flags clear.
    fifo_cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "pre_reset");
    tq.delete();
    divisor = 16'd16;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset/tick", 32'(tick), 32'd0);
    rxd = 1'b1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset/tick_count", 32'(tq.size()), 32'd1);
    check_state("midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencer and buffer for the UART receive core. It watches the synchronized RX line, generates the one-cycle baud_tick pulses that step the receive core (start-bit centering, then one tick per bit), checks the stop bit, and pushes each received byte into a show-ahead FIFO. The FIFO has a valid/ready read port for the bus/MMIO side, plus sticky overrun and framing error flags.

Parameters:
DataWidth, 8, bits per frame, must match the receive core
Depth, 8, FIFO entries, power of 2, >= 2
DivWidth, 16, width of the baud divisor (clk cycles per bit)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; asynchronous, active-high
en_i  input  1  receiver enable; sampled only in Idle
divisor_i  input  DivWidth  clk cycles per bit; captured at frame start; values < 4 treated as 4
rxd_i  input  1  raw serial line, same net that drives the core
baud_tick_o  output  1  one-cycle step pulse to the core's baud_clk_i
rx_dv_i  input  1  core data-valid pulse
rx_data_i  input  DataWidth  core received byte
rd_valid_o  output  1  FIFO non-empty
rd_ready_i  input  1  consumer pop; pop occurs when rd_valid_o & rd_ready_i
rd_data_o  output  DataWidth  FIFO head (show-ahead)
level_o  output  $clog2(Depth)+1  FIFO occupancy
flush_i  input  1  empty the FIFO synchronously
clr_err_i  input  1  clear sticky flags
overrun_o  output  1  sticky: a byte was dropped because the FIFO was full
framing_err_o  output  1  sticky: stop bit sampled low

Behaviour:
- Reset: all outputs 0, FSM Idle, FIFO empty, sync flops = 1, div counter 0, bit index 0.
- rxd_i passes through a 2-flop synchronizer (reset 1), giving rxd_s, plus a delayed copy rxd_d. Timing matches the core's internal sync.
- FSM states: Idle, StartWait, Bits.
- Idle: when en_i = 1 and a falling edge occurs (rxd_d = 1, rxd_s = 0):
  - latch div = max(divisor_i, 4);
  - load counter with div/2 - 1;
  - go to StartWait.
  - No ticks are issued in Idle.
- StartWait: decrement the counter; at 0, assert baud_tick_o for one cycle.
  - If rxd_s = 0: load counter div-1, bit_idx = 0, go to Bits.
  - If rxd_s = 1 (glitch): go to Idle. The tick is still issued; the core sees rxd high and stays Idle.
- Bits: decrement the counter; at 0, assert baud_tick_o, reload div-1, bit_idx++.
  - Ticks 0..DataWidth-1 are data bits.
  - Tick DataWidth is the stop bit: sample rxd_s; if 0, set framing_err_o. Go to Idle; no reload.
- A frame is DataWidth+2 ticks total. The first tick falls floor(div/2) cycles after the edge-detect cycle; later ticks are spaced exactly div cycles apart.
- en_i or divisor_i changes mid-frame do not affect the current frame. The frame always completes so the core never hangs mid-state.
- Push: rx_dv_i = 1 writes rx_data_i to the tail (framing error or not). rd_valid_o rises the cycle after a push into an empty FIFO.
- Full + push + no pop: byte dropped, overrun_o <= 1, contents unchanged.
- Full + push + pop in the same cycle: both occur, level unchanged, no overrun.
- Empty + pop request: ignored (rd_valid_o = 0).
- flush_i: pointers and level go to 0 next cycle and override a same-cycle push or pop. Sticky flags are unaffected.
- clr_err_i clears both flags next cycle. A same-cycle set event wins over clear.
- Pointers are log2(Depth) bits and wrap naturally. level_o counts 0..Depth.
- Reset mid-frame returns to Idle immediately; the core shares rst_i.

Test Plan:
- divisor = 16, frame 0xA5 (LSB first, stop = 1) -> ticks at edge+8, then +16 each, 10 ticks in total; rd_valid_o = 1; rd_data_o = 0xA5; level_o = 1; no flags.
- 1-cycle-wide low glitch on rxd_i, divisor = 16 -> exactly one tick at edge+8, FSM back in Idle, no push.
- Frame 0x3C with stop bit = 0 -> byte 0x3C pushed, framing_err_o = 1; clr_err_i pulse -> 0 next cycle.
- Depth = 8: send 9 bytes 0x00..0x08 with rd_ready_i = 0 -> level_o = 8, overrun_o = 1; pops return 0x00..0x07 in order.
- FIFO full, push and pop in the same cycle -> level stays 8, no overrun, head advances by one.
- divisor = 2 -> treated as 4 (first tick at edge+2, then spacing 4). en_i dropped mid-frame -> frame completes with all 10 ticks.
